id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32I core. Captures decoded fields and
//  the register-file read data at the end of ID, and presents them to EX one cycle later.
//  Supports EX stall (hold), flush/bubble insertion and an optional same-cycle WB->ID
//  bypass for a register-file write in WB. Also keeps a saturating bubble counter.
// PARAMETERS
//  XLEN    32  datapath width (must match word_t)
//  CNT_W   16  width of the bubble counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  id_valid     in   1        ID holds a real instruction this cycle
//  id_pc        in   XLEN     PC of ID instruction
//  id_rs1       in   5        source register 1 index
//  id_rs2       in   5        source register 2 index
//  id_rd        in   5        destination register index
//  id_imm       in   XLEN     sign-extended immediate
//  id_ctrl      in   ctrl_t   decoded control bundle (RISCV_pkg)
//  rf_rd1       in   XLEN     register-file read data for id_rs1 (combinational read)
//  rf_rd2       in   XLEN     register-file read data for id_rs2
//  wb_we        in   1        WB stage writes register file this cycle
//  wb_rd        in   5        WB destination index
//  wb_data      in   XLEN     WB write data
//  stall        in   1        EX not ready; hold all outputs
//  flush        in   1        insert bubble (branch redirect or load-use)
//  ex_valid     out  1        EX instruction valid
//  ex_pc        out  XLEN     registered PC
//  ex_rs1       out  5        registered rs1 (for EX forwarding unit)
//  ex_rs2       out  5        registered rs2
//  ex_rd        out  5        registered rd
//  ex_op1       out  XLEN     registered operand 1
//  ex_op2       out  XLEN     registered operand 2
//  ex_imm       out  XLEN     registered immediate
//  ex_ctrl      out  ctrl_t   registered control bundle
//  bubble_cnt   out  CNT_W    bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; ex_ctrl = CTRL_NOP (no reg write, no mem access); bubble_cnt = 0.
//  - Latency: 1 cycle. Values present on ID inputs at edge N appear on ex_* after edge N.
//  - Priority at each rising edge: flush > stall > load.
//  - Load (neither flush nor stall asserted): every ex_* <= matching id_* or operand; ex_valid <= id_valid.
//    If id_valid=0, ex_ctrl <= CTRL_NOP and ex_rd <= 0.
//  - Stall: all ex_* and bubble_cnt hold their values. Operands are not re-sampled.
//  - Flush (stall is ignored): ex_valid<=0, ex_ctrl<=CTRL_NOP, ex_rd/ex_rs1/ex_rs2<=0,
//    ex_op1/ex_op2/ex_imm/ex_pc<=0; bubble_cnt += 1 unless it is at all-ones (saturates).
//  - Operand select: op1 = bypass(id_rs1, rf_rd1) and op2 = bypass(id_rs2, rf_rd2); see CONFIGURATION.
//  - x0: a bypass never fires for index 0. op for rs=0 is always rf data, which is 0.
//  - Reset asserted mid-stall or mid-flush: immediate asynchronous return to reset values.
// CONFIGURATION
//  ID_EX_WB_BYPASS_EN defined: bypass(rs,rf) = (wb_we && wb_rd!=0 && wb_rd==rs) ? wb_data : rf.
//    This covers the register file writing on the same edge it is read.
//  Not defined: bypass(rs,rf) = rf. The hazard unit must then stall on a WB->ID distance-3 dependency.
//    wb_* ports remain but are unused.
// STRUCTURE
//  - RISCV_pkg: word_t, ctrl_t (packed: alu_op, alu_src, mem_rd, mem_wr, reg_wr,
//    wb_sel, branch, jump), and CTRL_NOP localparam (all zeros).
//  - Sub-module wb_bypass_mux (rs, rf_data, wb_we, wb_rd, wb_data -> op) is instantiated
//    twice. It is pure combinational. All registers live in id_ex_stage (single always_ff, async rst).
// TESTING
//  1 rst pulse mid-run -> all ex_* 0, ex_ctrl==CTRL_NOP, bubble_cnt==0 asynchronously.
//  2 id_pc=0x100, rf_rd1=0x5, rf_rd2=0xA, id_rd=3, valid -> next cycle ex_op1=0x5, ex_op2=0xA, ex_rd=3, ex_valid=1.
//  3 id_rs1=5, rf_rd1=0x5, wb_we=1, wb_rd=5, wb_data=0xDEAD -> ex_op1=0xDEAD (bypass build) or 0x5 (no-bypass build).
//  4 wb_rd=0, wb_we=1, id_rs2=0, wb_data=0xFFFF -> ex_op2=0.
//  5 stall held 3 cycles while id_* changes -> ex_* unchanged. Then release -> new values load.
//  6 flush and stall together -> bubble (ex_valid=0, ex_ctrl=NOP), bubble_cnt+1.
//    Force count to 0xFFFF then flush -> stays 0xFFFF.

Source files
------------

// File: rtl/RISCV_pkg.sv
// Shared RV32I pipeline types: datapath word, decoded control bundle
// and the ID/EX payload. Consumed by the ID/EX stage and its bypass mux.
package RISCV_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_wr;
    wb_sel_e wb_sel;
    logic    branch;
    logic    jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

  typedef struct packed {
    logic     valid;
    word_t    pc;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    word_t    op1;
    word_t    op2;
    word_t    imm;
    ctrl_t    ctrl;
  } id_ex_t;

  // All-zero payload: invalid, NOP control, x0 indices, zero data.
  localparam id_ex_t ID_EX_BUBBLE = id_ex_t'('0);

  // x0 is hard-wired, so a WB write to it must never be forwarded.
  function automatic logic wb_hit(
    input reg_idx_t rs,
    input logic     we,
    input reg_idx_t rd
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Operand select between register-file read data and the WB write data.
// Forwarding is compiled in only when ID_EX_WB_BYPASS_EN is defined.
module wb_bypass_mux
  import RISCV_pkg::*;
(
  input  reg_idx_t rs,
  input  word_t    rf_data,
  input  logic     wb_we,
  input  reg_idx_t wb_rd,
  input  word_t    wb_data,
  output word_t    op
);

`ifdef ID_EX_WB_BYPASS_EN
  assign op = wb_hit(rs, wb_we, wb_rd) ? wb_data : rf_data;
`else
  // Hazard unit stalls on the WB->ID dependency instead.
  logic unused_wb;
  assign unused_wb = ^{rs, wb_we, wb_rd, wb_data};
  assign op = rf_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and saturating bubble count.
// Optional WB->ID operand bypass enabled by ID_EX_WB_BYPASS_EN.
module id_ex_stage
  import RISCV_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_imm,
  input  ctrl_t            id_ctrl,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output ctrl_t            ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  word_t op1;
  word_t op2;

  wb_bypass_mux u_byp1 (
    .rs      (id_rs1),
    .rf_data (rf_rd1),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op1)
  );

  wb_bypass_mux u_byp2 (
    .rs      (id_rs2),
    .rf_data (rf_rd2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op2)
  );

  id_ex_t           pipe_q, pipe_d, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    load_d.valid = id_valid;
    load_d.pc    = id_pc;
    load_d.rs1   = id_rs1;
    load_d.rs2   = id_rs2;
    load_d.rd    = id_valid ? id_rd : '0;
    load_d.op1   = op1;
    load_d.op2   = op2;
    load_d.imm   = id_imm;
    load_d.ctrl  = id_valid ? id_ctrl : CTRL_NOP;
  end

  // Flush wins over stall so a redirect is never lost.
  always_comb begin
    pipe_d = pipe_q;
    cnt_d  = cnt_q;
    if (flush) begin
      pipe_d = ID_EX_BUBBLE;
      if (!(&cnt_q))
        cnt_d = cnt_q + CNT_W'(1);
    end else if (!stall) begin
      pipe_d = load_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= ID_EX_BUBBLE;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid   = pipe_q.valid;
  assign ex_pc      = pipe_q.pc;
  assign ex_rs1     = pipe_q.rs1;
  assign ex_rs2     = pipe_q.rs2;
  assign ex_rd      = pipe_q.rd;
  assign ex_op1     = pipe_q.op1;
  assign ex_op2     = pipe_q.op2;
  assign ex_imm     = pipe_q.imm;
  assign ex_ctrl    = pipe_q.ctrl;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: load, bypass, x0, stall,
// flush priority, counter saturation and asynchronous reset.
module tb_id_ex_stage;
  import RISCV_pkg::*;

  typedef struct packed {
    logic        v;
    word_t       pc;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    rd;
    word_t       op1;
    word_t       op2;
    word_t       imm;
    ctrl_t       ctrl;
    logic [15:0] cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  word_t       id_pc = '0;
  reg_idx_t    id_rs1 = '0;
  reg_idx_t    id_rs2 = '0;
  reg_idx_t    id_rd = '0;
  word_t       id_imm = '0;
  ctrl_t       id_ctrl = CTRL_NOP;
  word_t       rf_rd1 = '0;
  word_t       rf_rd2 = '0;
  logic        wb_we = 1'b0;
  reg_idx_t    wb_rd = '0;
  word_t       wb_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        ex_valid;
  word_t       ex_pc;
  reg_idx_t    ex_rs1;
  reg_idx_t    ex_rs2;
  reg_idx_t    ex_rd;
  word_t       ex_op1;
  word_t       ex_op2;
  word_t       ex_imm;
  ctrl_t       ex_ctrl;
  logic [15:0] bubble_cnt;

  int   total = 0;
  int   bad = 0;
  out_t m = '0;
  out_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_imm     (id_imm),
    .id_ctrl    (id_ctrl),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .stall      (stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_rd      (ex_rd),
    .ex_op1     (ex_op1),
    .ex_op2     (ex_op2),
    .ex_imm     (ex_imm),
    .ex_ctrl    (ex_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  function automatic out_t sample();
    out_t s;
    s.v    = ex_valid;
    s.pc   = ex_pc;
    s.rs1  = ex_rs1;
    s.rs2  = ex_rs2;
    s.rd   = ex_rd;
    s.op1  = ex_op1;
    s.op2  = ex_op2;
    s.imm  = ex_imm;
    s.ctrl = ex_ctrl;
    s.cnt  = bubble_cnt;
    return s;
  endfunction

  function automatic word_t byp(reg_idx_t rs, word_t rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs)
      return wb_data;
`endif
    return rf;
  endfunction

  function automatic out_t predict();
    out_t n;
    n = m;
    if (flush) begin
      n = '0;
      n.ctrl = CTRL_NOP;
      n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
    end else if (!stall) begin
      n.v    = id_valid;
      n.pc   = id_pc;
      n.rs1  = id_rs1;
      n.rs2  = id_rs2;
      n.rd   = id_valid ? id_rd : 5'd0;
      n.op1  = byp(id_rs1, rf_rd1);
      n.op2  = byp(id_rs2, rf_rd2);
      n.imm  = id_imm;
      n.ctrl = id_valid ? id_ctrl : CTRL_NOP;
    end
    return n;
  endfunction

  function automatic ctrl_t rand_ctrl();
    ctrl_t c;
    c.alu_op  = alu_op_e'($urandom_range(0, 10));
    c.alu_src = 1'($urandom_range(0, 1));
    c.mem_rd  = 1'($urandom_range(0, 1));
    c.mem_wr  = 1'($urandom_range(0, 1));
    c.reg_wr  = 1'($urandom_range(0, 1));
    c.wb_sel  = wb_sel_e'($urandom_range(0, 3));
    c.branch  = 1'($urandom_range(0, 1));
    c.jump    = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic rand_id();
    id_valid = 1'($urandom_range(0, 1));
    id_pc    = $urandom;
    id_rs1   = 5'($urandom_range(0, 31));
    id_rs2   = 5'($urandom_range(0, 31));
    id_rd    = 5'($urandom_range(0, 31));
    id_imm   = $urandom;
    id_ctrl  = rand_ctrl();
    rf_rd1   = $urandom;
    rf_rd2   = $urandom;
    wb_we    = 1'($urandom_range(0, 1));
    wb_rd    = $urandom_range(0, 3) == 0 ? id_rs1 : 5'($urandom_range(0, 31));
    wb_data  = $urandom;
  endtask

  // Drive is already applied; record the expectation and clock it in.
  task automatic step();
    m = predict();
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t g;
    #3;
    g = sample();
    total++;
    if (g !== out_t'('0)) begin
      bad++;
      $display("FAIL reset: got=%h want=%h", g, out_t'('0));
    end
    @(negedge clk);
    rst = 1'b0;
    m = '0;
    @(posedge clk);
    #1;
    g = sample();
    total++;
    if (g !== out_t'('0)) begin
      bad++;
      $display("FAIL reset_idle: got=%h want=%h", g, out_t'('0));
    end
  endtask

  task automatic test_load();
    out_t e, g;
    id_valid = 1'b1;
    id_pc    = 32'h100;
    id_rs1   = 5'd1;
    id_rs2   = 5'd2;
    id_rd    = 5'd3;
    id_imm   = 32'h10;
    id_ctrl  = rand_ctrl();
    rf_rd1   = 32'h5;
    rf_rd2   = 32'hA;
    wb_we    = 1'b0;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL load: got=%h want=%h", g, e);
    end
    total++;
    if ({ex_valid, ex_rd, ex_op1, ex_op2} !== {1'b1, 5'd3, 32'h5, 32'hA}) begin
      bad++;
      $display("FAIL load_fields: got v=%0d rd=%0d op1=%h op2=%h want 1 3 5 a",
               ex_valid, ex_rd, ex_op1, ex_op2);
    end
    for (int i = 0; i < 10; i++) begin
      rand_id();
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL load_rand%0d: got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_bypass();
    word_t want;
    out_t  e, g;
    id_valid = 1'b1;
    id_rs1   = 5'd5;
    id_rs2   = 5'd6;
    rf_rd1   = 32'h5;
    rf_rd2   = 32'h6;
    wb_we    = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hDEAD;
`ifdef ID_EX_WB_BYPASS_EN
    want = 32'hDEAD;
`else
    want = 32'h5;
`endif
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e || ex_op1 !== want || ex_op2 !== 32'h6) begin
      bad++;
      $display("FAIL bypass: got op1=%h op2=%h want op1=%h op2=6 (%h vs %h)",
               ex_op1, ex_op2, want, g, e);
    end
    wb_we = 1'b0;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e || ex_op1 !== 32'h5) begin
      bad++;
      $display("FAIL bypass_we0: got op1=%h want 5", ex_op1);
    end
  endtask

  task automatic test_x0();
    out_t e, g;
    id_valid = 1'b1;
    id_rs1   = 5'd0;
    id_rs2   = 5'd0;
    rf_rd1   = 32'h0;
    rf_rd2   = 32'h0;
    wb_we    = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'hFFFF;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e || ex_op1 !== 32'h0 || ex_op2 !== 32'h0) begin
      bad++;
      $display("FAIL x0: got op1=%h op2=%h want 0 0", ex_op1, ex_op2);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_stall();
    out_t e, g, held;
    rand_id();
    id_valid = 1'b1;
    step();
    e = sb.pop_front();
    held = sample();
    total++;
    if (held !== e) begin
      bad++;
      $display("FAIL stall_pre: got=%h want=%h", held, e);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e || g !== held) begin
        bad++;
        $display("FAIL stall_hold%0d: got=%h want=%h", i, g, e);
      end
    end
    stall = 1'b0;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL stall_release: got=%h want=%h", g, e);
    end
  endtask

  task automatic test_flush();
    out_t e, g;
    logic [15:0] c0;
    rand_id();
    id_valid = 1'b1;
    c0 = m.cnt;
    stall = 1'b1;
    flush = 1'b1;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e || ex_valid !== 1'b0 || ex_ctrl !== CTRL_NOP
        || bubble_cnt !== c0 + 16'd1) begin
      bad++;
      $display("FAIL flush_stall: got=%h want=%h", g, e);
    end
    stall = 1'b0;
    step();
    e = sb.pop_front();
    g = sample();
    total++;
    if (g !== e || bubble_cnt !== c0 + 16'd2) begin
      bad++;
      $display("FAIL flush2: got cnt=%h want=%h", bubble_cnt, c0 + 16'd2);
    end
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m.cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e || bubble_cnt !== 16'hFFFF) begin
        bad++;
        $display("FAIL flush_sat%0d: got cnt=%h want=ffff", i, bubble_cnt);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_t e, g;
    for (int i = 0; i < 40; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 4) == 0);
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL b2b%0d: got=%h want=%h", i, g, e);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_t g;
    rand_id();
    id_valid = 1'b1;
    step();
    void'(sb.pop_front());
    stall = 1'b1;
    flush = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    g = sample();
    total++;
    if (g !== out_t'('0)) begin
      bad++;
      $display("FAIL reset_mid: got=%h want=%h", g, out_t'('0));
    end
    @(posedge clk);
    #1;
    g = sample();
    total++;
    if (g !== out_t'('0)) begin
      bad++;
      $display("FAIL reset_hold: got=%h want=%h", g, out_t'('0));
    end
    stall = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m = '0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_bypass();
    test_x0();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
